// File: rtl/dpll_frame_sync_pkg.sv
// Shared types, default parameters and frame-length helper for the frame synchroniser.
package dpll_frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int          DEF_SYNC_WIDTH   = 8;
  localparam logic [31:0] DEF_SYNC_PATTERN = 32'h0000_00A5;
  localparam int          DEF_WORD_WIDTH   = 8;
  localparam int          DEF_FRAME_WORDS  = 4;
  localparam int          DEF_VERIFY_CNT   = 2;
  localparam int          DEF_MISS_LIMIT   = 3;

  function automatic int frame_len(input int sync_w, input int word_w, input int frame_words);
    return sync_w + frame_words * word_w;
  endfunction

endpackage

// File: rtl/dpll_word_asm.sv
// Payload word assembler: MSB-first shift register with a bit-in-word counter and a
// registered done pulse one cycle after the bit that completes a word.
module dpll_word_asm
  import dpll_frame_sync_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_shift,
  input  logic                  i_clr,
  input  logic                  i_bit,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_done
);

  localparam int             CW       = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] r_sr;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;
  logic [WORD_WIDTH-1:0] w_next;

  if (WORD_WIDTH == 1) begin : g_w1
    assign w_next = i_bit;
  end else begin : g_wn
    assign w_next = {r_sr[WORD_WIDTH-2:0], i_bit};
  end

  // The register keeps shifting into the next word; o_word is only meaningful with o_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_shift) begin
        r_sr <= w_next;
        if (r_cnt == CNT_LAST) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_word = r_sr;
  assign o_done = r_done;

endmodule

// File: rtl/dpll_frame_sync.sv
// Frame synchroniser after the DPLL data-recovery stage: hunt, verify, lock, word assembly.
// Optional DPLL_FRAME_SYNC_INV_EN: accept the inverted sync word and correct polarity.
module dpll_frame_sync
  import dpll_frame_sync_pkg::*;
#(
  parameter int                    SYNC_WIDTH   = DEF_SYNC_WIDTH,
  parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN[SYNC_WIDTH-1:0],
  parameter int                    WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int                    FRAME_WORDS  = DEF_FRAME_WORDS,
  parameter int                    VERIFY_CNT   = DEF_VERIFY_CNT,
  parameter int                    MISS_LIMIT   = DEF_MISS_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_ready,
  input  logic                  data_in,
  input  logic                  flush,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_first,
  output logic                  locked,
  output logic                  sync_err
`ifdef DPLL_FRAME_SYNC_INV_EN
  ,
  output logic                  polarity_inv
`endif
);

  localparam int PAY_LEN   = FRAME_WORDS * WORD_WIDTH;
  localparam int FRAME_LEN = frame_len(SYNC_WIDTH, WORD_WIDTH, FRAME_WORDS);
  localparam int BCW       = $clog2(FRAME_LEN);
  localparam int GW        = $clog2(VERIFY_CNT + 1);
  localparam int MW        = $clog2(MISS_LIMIT + 1);

  localparam logic [BCW-1:0] BC_LAST   = BCW'(FRAME_LEN - 1);
  localparam logic [BCW-1:0] BC_PAY    = BCW'(PAY_LEN);
  localparam logic [BCW-1:0] BC_WORD   = BCW'(WORD_WIDTH);
  localparam logic [GW-1:0]  GOOD_LIM  = GW'(VERIFY_CNT);
  localparam logic [MW-1:0]  MISS_LIM  = MW'(MISS_LIMIT);

  state_t                r_state;
  state_t                w_next_state;
  logic [BCW-1:0]        r_bcnt;
  logic [GW-1:0]         r_good;
  logic [MW-1:0]         r_miss;
  // Only the newest SYNC_WIDTH-1 bits are kept; the oldest is shifted out before any compare.
  logic [SYNC_WIDTH-2:0] r_sync_hist;
  logic                  r_sync_err;
  logic                  r_first;

  logic                  w_rx_bit;
  logic [SYNC_WIDTH-1:0] w_sync_next;
  logic                  w_hit;
  logic                  w_hit_inv;
  logic                  w_sync_slot;
  logic [GW-1:0]         w_good_inc;
  logic [MW-1:0]         w_miss_inc;
  logic                  w_shift;
  logic                  w_asm_clr;
  logic                  w_sync_err;
  logic                  w_asm_done;

`ifdef DPLL_FRAME_SYNC_INV_EN
  logic r_inv;
  assign w_rx_bit     = data_in ^ r_inv;
  assign w_hit_inv    = (w_sync_next == ~SYNC_PATTERN);
  assign polarity_inv = r_inv;
`else
  assign w_rx_bit  = data_in;
  assign w_hit_inv = 1'b0;
`endif

  // bit_ready is a one-cycle strobe with no back-pressure: every strobed bit is consumed,
  // flush wins over a coincident strobe, and all state holds on non-strobe cycles.
  assign w_sync_next = {r_sync_hist, w_rx_bit};
  assign w_hit       = (w_sync_next == SYNC_PATTERN);
  assign w_sync_slot = (r_bcnt == BC_LAST);
  assign w_good_inc  = r_good + 1'b1;
  assign w_miss_inc  = r_miss + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = HUNT;
    end else if (bit_ready) begin
      case (r_state)
        HUNT:   if (w_hit || w_hit_inv) w_next_state = VERIFY;
        VERIFY: if (w_sync_slot) begin
                  if (!w_hit)                      w_next_state = HUNT;
                  else if (w_good_inc == GOOD_LIM) w_next_state = LOCKED;
                end
        LOCKED: if (w_sync_slot && !w_hit && (w_miss_inc == MISS_LIM)) w_next_state = HUNT;
        default: w_next_state = HUNT;
      endcase
    end
  end

  always_comb begin
    w_shift    = 1'b0;
    w_asm_clr  = 1'b1;
    w_sync_err = 1'b0;
    if (!flush && (r_state == LOCKED)) begin
      w_asm_clr = 1'b0;
      w_shift   = bit_ready && (r_bcnt < BC_PAY);
    end
    if (bit_ready && !flush && (r_state != HUNT) && w_sync_slot && !w_hit) w_sync_err = 1'b1;
  end

  // Any exit to HUNT clears the frame counters so re-acquisition always starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt      <= '0;
      r_good      <= '0;
      r_miss      <= '0;
      r_sync_hist <= '0;
`ifdef DPLL_FRAME_SYNC_INV_EN
      r_inv       <= 1'b0;
`endif
    end else if (flush) begin
      r_bcnt      <= '0;
      r_good      <= '0;
      r_miss      <= '0;
      r_sync_hist <= '0;
`ifdef DPLL_FRAME_SYNC_INV_EN
      r_inv       <= 1'b0;
`endif
    end else if (bit_ready) begin
      r_sync_hist <= w_sync_next[SYNC_WIDTH-2:0];
      if ((r_state == HUNT) || (w_next_state == HUNT)) begin
        r_bcnt <= '0;
        r_good <= '0;
        r_miss <= '0;
`ifdef DPLL_FRAME_SYNC_INV_EN
        r_inv  <= (r_state == HUNT) && w_hit_inv && !w_hit;
`endif
      end else begin
        r_bcnt <= w_sync_slot ? '0 : r_bcnt + 1'b1;
        if (w_sync_slot) begin
          if (r_state == VERIFY) begin
            r_good <= w_good_inc;
            r_miss <= '0;
          end else begin
            r_miss <= w_hit ? '0 : w_miss_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_err <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      r_sync_err <= w_sync_err;
      r_first    <= w_shift && (r_bcnt < BC_WORD);
    end
  end

  dpll_word_asm #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_word_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_shift (w_shift),
    .i_clr   (w_asm_clr),
    .i_bit   (w_rx_bit),
    .o_word  (word_data),
    .o_done  (w_asm_done)
  );

  assign word_valid = w_asm_done;
  assign word_first = w_asm_done && r_first;
  assign locked     = (r_state == LOCKED);
  assign sync_err   = r_sync_err;

endmodule

// File: doc/dpll_frame_sync.md
Name: dpll_frame_sync

Overview:
- Consumes the recovered serial stream (bit_ready strobe plus 1-bit data) from the digital PLL data-recovery stage, one stage downstream of it.
- Hunts for a fixed sync word, confirms frame alignment over several frames and declares lock.
- While locked, assembles payload bits into parallel words with frame-start marking, and tracks loss of sync.

Parameters:
- SYNC_WIDTH, 8, sync word length in bits (2..32)
- SYNC_PATTERN, 8'hA5, sync word value, first-received bit is the MSB
- WORD_WIDTH, 8, payload word width in bits (1..32)
- FRAME_WORDS, 4, payload words per frame (1..256)
- VERIFY_CNT, 2, consecutive good syncs after the first hit required to lock (1..15)
- MISS_LIMIT, 3, consecutive bad syncs while locked that force re-hunt (1..15)

Ports:
- clk, input, 1, system clock (same clock as the PLL stage)
- rst_n, input, 1, asynchronous active-low reset
- bit_ready, input, 1, one-cycle strobe: data_in holds a valid recovered bit
- data_in, input, 1, recovered serial bit
- flush, input, 1, synchronous return to HUNT
- word_valid, output, 1, one-cycle pulse: word_data is valid
- word_data, output, WORD_WIDTH, assembled word, first-received bit in MSB
- word_first, output, 1, qualifies word_valid; high for word 0 of a frame
- locked, output, 1, high in LOCKED state
- sync_err, output, 1, one-cycle pulse on every sync mismatch in VERIFY or LOCKED

Behaviour:
- Reset state: FSM=HUNT; all counters and shift registers 0. Outputs reset to 0: word_valid, word_data, word_first, locked, sync_err.
- All state advances only on cycles with bit_ready=1. Non-strobe cycles hold all state; pulse outputs are 0 on those cycles.
- sync_sr: SYNC_WIDTH-bit shift-in-at-LSB history of the received bits.
- Frame = SYNC_WIDTH sync bits followed by FRAME_WORDS*WORD_WIDTH payload bits. Bit counter bcnt counts 0..FRAME_LEN-1, then wraps to 0.
- HUNT: on each strobe, compare {sync_sr[SYNC_WIDTH-2:0],data_in} to SYNC_PATTERN.
  - Match -> VERIFY; bcnt=0, which marks the first payload bit next; good=0.
- VERIFY/LOCKED: bcnt increments per strobe. Bits with bcnt < payload length feed the word assembler. Bits at the remaining positions are sync positions.
  - At the strobe completing the sync field, compare the new sync_sr value to SYNC_PATTERN.
- VERIFY:
  - Match: good+1. When good reaches VERIFY_CNT -> LOCKED, miss=0.
  - Mismatch: sync_err pulse -> HUNT.
  - No words are emitted in VERIFY.
- LOCKED:
  - Each WORD_WIDTH payload bits, word_valid pulses in the cycle after the strobe that completes the word (latency 1).
  - word_first=1 on word 0 of the frame.
  - Sync match: miss=0. Mismatch: sync_err, miss+1; miss==MISS_LIMIT -> HUNT, locked drops the next cycle.
  - Frame counting continues across a mismatch, so alignment is not re-searched until HUNT.
- flush=1: next state HUNT, counters cleared. flush overrides a simultaneous bit_ready; no word_valid or sync_err is generated that cycle.
- A word partly assembled when leaving LOCKED is discarded. The first word after re-lock is always word 0 of a frame.
- Counter widths: $clog2 of their maximum +1. No counter ever exceeds its limit, and no silent wrap other than the bcnt frame wrap.

Optional Feature:
- Macro: DPLL_FRAME_SYNC_INV_EN.
- Defined:
  - HUNT also accepts ~SYNC_PATTERN; this sets an inv flag that XORs every subsequent data_in and holds until the next return to HUNT.
  - The flag is exported on an extra port, polarity_inv output 1, reset 0.
- Undefined: only the true pattern is accepted, and the polarity_inv port does not exist.

Decomposition:
- Package dpll_frame_sync_pkg holds:
  - state enum {HUNT, VERIFY, LOCKED}, 2 bits
  - default parameter constants
  - function computing FRAME_LEN = SYNC_WIDTH + FRAME_WORDS*WORD_WIDTH
- One sub-module, dpll_word_asm: shift register plus bit-in-word counter. Inputs are shift enable, clear and bit; outputs are the word and a done pulse. It is instantiated once; the FSM and counters stay in the top.

Test Plan:
- Reset/idle: hold rst_n=0, then no bit_ready -> all outputs 0, locked=0 indefinitely.
- Clean acquisition: 4 frames of A5 + payload 11,22,33,44, defaults.
  - Lock: locked=1 after the 3rd sync.
  - 4th frame: word_valid ×4 with data 11,22,33,44, word_first only on 11.
- False sync: A5 embedded in payload while in HUNT -> VERIFY; the next sync slot mismatches -> sync_err=1, state HUNT, no word_valid.
- Loss of lock: locked stream, then corrupt sync 3 consecutive frames.
  - sync_err ×3, locked=0 after the 3rd.
  - If only 2 syncs are corrupted, lock is held and miss clears.
- Flush and sparse strobes: bit_ready every 5 cycles with flush asserted mid-word, coincident with bit_ready -> HUNT, no word emitted, re-acquisition as in the clean case.
- Inversion (feature on): send ~A5 frames with inverted payload -> lock, polarity_inv=1, words 11,22,33,44 recovered.
